// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with HI/LO registers.
// MULT/MULTU use shift-add, DIV/DIVU use restoring division; both work on
// operand magnitudes for 32 iterations, then a FIX cycle applies sign
// correction and commits HI/LO, followed by a one-cycle DONE pulse.
module muldiv_unit #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic [DATA_W-1:0] operand_1,
    input  logic [DATA_W-1:0] operand_2,
    input  logic              flush,
    input  logic              hi_write_en,
    input  logic              lo_write_en,
    input  logic [DATA_W-1:0] write_data,
    output logic              busy,
    output logic              done,
    output logic              div_zero,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo
);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(DATA_W - 1);

    state_t              state;
    logic [CNT_W-1:0]    cnt;
    logic [DATA_W-1:0]   acc_hi;    // upper product half, or partial remainder
    logic [DATA_W-1:0]   acc_lo;    // lower product half / multiplier, or dividend/quotient
    logic [DATA_W-1:0]   opb;       // multiplicand or divisor magnitude
    logic                is_div;
    logic                res_sign;
    logic                rem_sign;

    logic                accept;
    logic                op_signed;
    logic                op_div;
    logic [DATA_W-1:0]   mag_1;
    logic [DATA_W-1:0]   mag_2;
    logic [DATA_W:0]     mul_sum;
    logic [DATA_W:0]     div_shift;
    logic [DATA_W+1:0]   div_diff;
    logic [2*DATA_W-1:0] prod_raw;
    logic [2*DATA_W-1:0] prod_fix;
    logic [DATA_W-1:0]   quo_fix;
    logic [DATA_W-1:0]   rem_fix;

    // Request decode, operand magnitudes, one datapath step and sign fix-up.
    always_comb begin
        accept    = (state == IDLE) && start && !flush;
        op_signed = ~op[0];
        op_div    = op[1];
        mag_1     = (op_signed && operand_1[DATA_W-1]) ? -operand_1 : operand_1;
        mag_2     = (op_signed && operand_2[DATA_W-1]) ? -operand_2 : operand_2;
        // Shift-add: add multiplicand into the upper half when the current
        // multiplier bit is set, then shift the whole 64-bit register right.
        mul_sum   = {1'b0, acc_hi} + {1'b0, (acc_lo[0] ? opb : '0)};
        // Restoring division: shift {rem, dividend} left one bit and trial
        // subtract; the extra top bit of div_diff is the borrow.
        div_shift = {acc_hi, acc_lo[DATA_W-1]};
        div_diff  = {1'b0, div_shift} - {2'b00, opb};
        prod_raw  = {acc_hi, acc_lo};
        prod_fix  = res_sign ? -prod_raw : prod_raw;
        quo_fix   = res_sign ? -acc_lo : acc_lo;
        rem_fix   = rem_sign ? -acc_hi : acc_hi;
        busy      = accept || (state == CALC) || (state == FIX);
    end

    // Control FSM, iteration datapath and HI/LO architectural registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            acc_hi   <= '0;
            acc_lo   <= '0;
            opb      <= '0;
            is_div   <= 1'b0;
            res_sign <= 1'b0;
            rem_sign <= 1'b0;
            done     <= 1'b0;
            div_zero <= 1'b0;
            hi       <= '0;
            lo       <= '0;
        end else begin
            done     <= 1'b0;
            div_zero <= 1'b0;
            // MTHI/MTLO only land while no operation owns HI/LO; the FIX
            // commit below is later in the block so it would win anyway.
            if ((state == IDLE) || (state == DONE)) begin
                if (hi_write_en) hi <= write_data;
                if (lo_write_en) lo <= write_data;
            end
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (op_div && (operand_2 == '0)) begin
                            state    <= DONE;
                            done     <= 1'b1;
                            div_zero <= 1'b1;
                        end else begin
                            is_div   <= op_div;
                            res_sign <= op_signed & (operand_1[DATA_W-1] ^ operand_2[DATA_W-1]);
                            rem_sign <= op_signed & operand_1[DATA_W-1];
                            cnt      <= '0;
                            acc_hi   <= '0;
                            acc_lo   <= op_div ? mag_1 : mag_2;
                            opb      <= op_div ? mag_2 : mag_1;
                            state    <= CALC;
                        end
                    end
                end
                CALC: begin
                    if (flush) begin
                        state <= IDLE;
                    end else begin
                        if (is_div) begin
                            if (!div_diff[DATA_W+1]) begin
                                acc_hi <= div_diff[DATA_W-1:0];
                                acc_lo <= {acc_lo[DATA_W-2:0], 1'b1};
                            end else begin
                                acc_hi <= div_shift[DATA_W-1:0];
                                acc_lo <= {acc_lo[DATA_W-2:0], 1'b0};
                            end
                        end else begin
                            acc_hi <= mul_sum[DATA_W:1];
                            acc_lo <= {mul_sum[0], acc_lo[DATA_W-1:1]};
                        end
                        cnt <= cnt + 1'b1;
                        if (cnt == LAST_ITER) state <= FIX;
                    end
                end
                FIX: begin
                    if (flush) begin
                        state <= IDLE;
                    end else begin
                        if (is_div) begin
                            lo <= quo_fix;
                            hi <= rem_fix;
                        end else begin
                            hi <= prod_fix[2*DATA_W-1:DATA_W];
                            lo <= prod_fix[DATA_W-1:0];
                        end
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed testbench for muldiv_unit: hand-computed vectors, immediate
// assertions at each comparison point, one summary line at the end.
module tb_muldiv_unit;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] operand_1;
    logic [31:0] operand_2;
    logic        flush;
    logic        hi_write_en;
    logic        lo_write_en;
    logic [31:0] write_data;
    logic        busy;
    logic        done;
    logic        div_zero;
    logic [31:0] hi;
    logic [31:0] lo;

    int errors = 0;
    int checks = 0;

    muldiv_unit #(.DATA_W(32), .CNT_W(6)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .op          (op),
        .operand_1   (operand_1),
        .operand_2   (operand_2),
        .flush       (flush),
        .hi_write_en (hi_write_en),
        .lo_write_en (lo_write_en),
        .write_data  (write_data),
        .busy        (busy),
        .done        (done),
        .div_zero    (div_zero),
        .hi          (hi),
        .lo          (lo)
    );

    // Clock
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Issue one operation and follow it to completion.
    // inj   : CALC cycle index at which an MTHI strobe is attempted (0 = none)
    // dmode : 1 = raise start during DONE, 2 = raise flush during DONE
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                          input string tag, input int inj, input int dmode);
        logic [31:0] hi_before;
        int          bad;
        bad = 0;
        @(negedge clk);
        op = o; operand_1 = a; operand_2 = b; start = 1'b1;
        #1 check({tag, "_busy_req"}, busy, 1);
        hi_before = hi;
        @(posedge clk);
        #1 start = 1'b0;
        for (int k = 1; k <= 33; k++) begin
            @(negedge clk);
            if (busy !== 1'b1 || done !== 1'b0) bad++;
            if (inj != 0 && k == inj) begin
                hi_write_en = 1'b1;
                write_data  = 32'hDEAD_BEEF;
            end
            if (inj != 0 && k == inj + 1) begin
                hi_write_en = 1'b0;
                check({tag, "_mthi_ignored"}, hi, hi_before);
            end
        end
        check({tag, "_busy_window"}, bad, 0);
        @(negedge clk);
        check({tag, "_done"}, done, 1);
        check({tag, "_div_zero"}, div_zero, 0);
        check({tag, "_busy_done"}, busy, 0);
        check({tag, "_hi"}, hi, exp_hi);
        check({tag, "_lo"}, lo, exp_lo);
        if (dmode == 1) begin
            start = 1'b1;
            #1 check({tag, "_busy_start_in_done"}, busy, 0);
        end
        if (dmode == 2) begin
            flush = 1'b1;
            #1 check({tag, "_done_under_flush"}, done, 1);
        end
        @(posedge clk);
        #1 start = 1'b0; flush = 1'b0;
        @(negedge clk);
        check({tag, "_done_pulse_end"}, done, 0);
        check({tag, "_idle_after"}, busy, 0);
    endtask

    initial begin
        int seen;
        rst_n = 1'b0; start = 1'b0; op = 2'b00; operand_1 = '0; operand_2 = '0;
        flush = 1'b0; hi_write_en = 1'b0; lo_write_en = 1'b0; write_data = '0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_div_zero", div_zero, 0);
        check("rst_hi", hi, 0);
        check("rst_lo", lo, 0);
        rst_n = 1'b1;

        // MTHI / MTLO in IDLE
        hi_write_en = 1'b1; write_data = 32'h1234_5678;
        @(posedge clk);
        #1 hi_write_en = 1'b0; lo_write_en = 1'b1; write_data = 32'h9ABC_DEF0;
        @(posedge clk);
        #1 lo_write_en = 1'b0;
        @(negedge clk);
        check("mthi", hi, 32'h1234_5678);
        check("mtlo", lo, 32'h9ABC_DEF0);

        // Arithmetic vectors
        run_op(OP_MULT,  32'hFFFF_FFFB, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFF1, "mult_neg", 0, 0);
        run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, "multu_max", 0, 0);
        run_op(OP_MULT,  32'h0000_0007, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFF2, "mult_pos_neg", 0, 1);
        run_op(OP_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, "div_neg", 0, 0);
        run_op(OP_DIV,   32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, "div_pos_neg", 0, 2);
        run_op(OP_DIV,   32'h8000_0000, 32'h0000_0001, 32'h0000_0000, 32'h8000_0000, "div_minint", 0, 0);
        run_op(OP_DIVU,  32'd100,       32'd7,         32'd2,         32'd14,        "divu_100_7", 5, 0);

        // DIVU by zero: done next cycle, HI/LO untouched
        @(negedge clk);
        op = OP_DIVU; operand_1 = 32'd5; operand_2 = 32'd0; start = 1'b1;
        #1 check("dz_busy_req", busy, 1);
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        check("dz_done", done, 1);
        check("dz_flag", div_zero, 1);
        check("dz_hi", hi, 32'd2);
        check("dz_lo", lo, 32'd14);
        @(negedge clk);
        check("dz_done_end", done, 0);
        check("dz_flag_end", div_zero, 0);

        // flush together with start in IDLE: request dropped
        op = OP_MULT; operand_1 = 32'd3; operand_2 = 32'd4; start = 1'b1; flush = 1'b1;
        #1 check("fs_busy", busy, 0);
        @(posedge clk);
        #1 start = 1'b0; flush = 1'b0;
        @(negedge clk);
        check("fs_not_accepted", busy, 0);

        // flush at T+10 of a MULT
        op = OP_MULT; operand_1 = 32'd7; operand_2 = 32'd5; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (10) @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        @(negedge clk);
        check("fl_busy", busy, 0);
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (done === 1'b1) seen++;
        end
        check("fl_no_done", seen, 0);
        check("fl_hi", hi, 32'd2);
        check("fl_lo", lo, 32'd14);

        // reset at T+20, with a concurrent MTHI strobe that must lose
        op = OP_MULTU; operand_1 = 32'd9; operand_2 = 32'd9; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (20) @(negedge clk);
        rst_n = 1'b0; hi_write_en = 1'b1; write_data = 32'hCAFE_F00D;
        @(posedge clk);
        #1 rst_n = 1'b1; hi_write_en = 1'b0;
        @(negedge clk);
        check("mr_busy", busy, 0);
        check("mr_done", done, 0);
        check("mr_div_zero", div_zero, 0);
        check("mr_hi", hi, 0);
        check("mr_lo", lo, 0);
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (done === 1'b1) seen++;
        end
        check("mr_no_done", seen, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
